// File: rtl/param_receiver_if.sv
// Receive-side bus of the UART receiver: serial line in, FIFO head word out with ready/valid pop.
interface param_receiver_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rxIn;
    logic [DATA_BITS-1:0] rxData;
    logic                 parityErr;
    logic                 frameErr;
    logic                 rxValid;
    logic                 rxReady;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rxIn, rxReady,
        output rxData, parityErr, frameErr, rxValid, overrun, busy
    );

    modport slave (
        output rxIn, rxReady,
        input  rxData, parityErr, frameErr, rxValid, overrun, busy
    );
endinterface

// File: rtl/param_receiver.sv
// UART receiver: 2-flop line synchronizer, framing FSM with optional parity,
// and a small receive FIFO whose head word, flags and valid are all registered.
module param_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned DEPTH        = 4
) (
    input logic             clk,
    input logic             rstN,
    param_receiver_if.master bus
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 perr;
        logic                 ferr;
    } word_t;

    logic                 rx_meta;
    logic                 rxS;
    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 busy_q;

    // Line synchronizer; idles high so reset must not look like a start edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_meta <= 1'b1;
            rxS     <= 1'b1;
        end else begin
            rx_meta <= bus.rxIn;
            rxS     <= rx_meta;
        end
    end

    logic  mid_c;
    logic  tick_c;
    logic  par_exp_c;
    logic  push_c;
    word_t push_word_c;

    assign mid_c     = (baud_cnt == BAUD_W'(CLKS_PER_BIT / 2 - 1));
    assign tick_c    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign par_exp_c = (^shift) ^ (PARITY == 1);
    assign push_c    = (state == ST_STOP) && tick_c && (stop_cnt == 1'(STOP_BITS - 1));

    // The last stop sample folds straight into the pushed frame-error flag.
    always_comb begin
        push_word_c      = '0;
        push_word_c.data = shift;
        push_word_c.perr = perr_q;
        push_word_c.ferr = ferr_q | ~rxS;
    end

    // Framing FSM; busy is registered alongside each state transition.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxS) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (mid_c) begin
                        if (rxS) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state    <= ST_DATA;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            perr_q   <= 1'b0;
                            ferr_q   <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        shift    <= {rxS, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt  <= '0;
                            stop_cnt <= 1'b0;
                            state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        perr_q   <= (rxS != par_exp_c);
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        ferr_q   <= ferr_q | ~rxS;
                        if (push_c) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    word_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              valid_q;
    word_t             head_q;
    logic              overrun_q;

    logic              pop_c;
    logic              full_c;
    logic              wr_en_c;
    logic [CNT_W-1:0]  count_next_c;
    logic [PTR_W-1:0]  rd_next_c;
    word_t             head_next_c;

    // Next-cycle head: a word written into the slot about to become head bypasses the array.
    always_comb begin
        pop_c        = valid_q && bus.rxReady;
        full_c       = (count == CNT_W'(DEPTH));
        wr_en_c      = push_c && (!full_c || pop_c);
        count_next_c = count;
        if (wr_en_c && !pop_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (!wr_en_c && pop_c) begin
            count_next_c = count - CNT_W'(1);
        end
        rd_next_c   = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        head_next_c = mem[rd_next_c];
        if (wr_en_c && (rd_next_c == wr_ptr)) begin
            head_next_c = push_word_c;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= push_word_c;
        end
    end

    // Head word and flags only update while the FIFO stays non-empty, so they hold when drained.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_q   <= 1'b0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next_c;
            valid_q   <= (count_next_c != '0);
            overrun_q <= push_c && full_c && !pop_c;
            if (count_next_c != '0) begin
                head_q <= head_next_c;
            end
        end
    end

    assign bus.rxData    = head_q.data;
    assign bus.parityErr = head_q.perr;
    assign bus.frameErr  = head_q.ferr;
    assign bus.rxValid   = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/param_receiver.md
PARAM_RECEIVER -- requirements
Module: param_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per bit period; SHALL be an even value >= 4.
REQ-002 Parameter: DATA_BITS, 8, data bits per frame; SHALL be in range 5..9.
REQ-003 Parameter: PARITY, 0, parity mode; 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter: STOP_BITS, 1, stop bits per frame; SHALL be 1 or 2.
REQ-005 Parameter: DEPTH, 4, receive FIFO entries; SHALL be a power of 2, >= 2.
REQ-006 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-007 Port: rstN  in  1  reset, asynchronous assertion, active-low.
REQ-008 Port: rxIn  in  1  serial line, asynchronous to clk, idle high.
REQ-009 Port: rxData  out  DATA_BITS  received word at FIFO head.
REQ-010 Port: parityErr  out  1  parity mismatch flag for the head word; 0 when PARITY = 0.
REQ-011 Port: frameErr  out  1  stop-bit error flag for the head word.
REQ-012 Port: rxValid  out  1  FIFO non-empty; rxData and the error flags are valid.
REQ-013 Port: rxReady  in  1  consumer accepts the head word.
REQ-014 Port: overrun  out  1  one-cycle pulse; a complete frame was dropped because the FIFO was full.
REQ-015 Port: busy  out  1  high in every state except IDLE.

Function
REQ-016 rxIn SHALL pass through a 2-flop synchronizer; both flops reset to 1. All sampling uses the synchronized value rxS.
REQ-017 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-018 Bit counter and baud counter SHALL be sized to hold their maximum values (DATA_BITS-1 and CLKS_PER_BIT-1).
REQ-019 IDLE: when rxS = 0, go to START and clear the baud counter. Otherwise stay in IDLE.
REQ-020 START: at baud count CLKS_PER_BIT/2-1 (mid-bit), sample rxS.
- rxS = 1: false start; return to IDLE and record nothing.
- rxS = 0: go to DATA with the baud and bit counters cleared.
REQ-021 DATA: sample rxS at every baud count CLKS_PER_BIT-1, which wraps the baud counter to 0.
- Data SHALL be shifted in LSB first.
- After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise to STOP.
REQ-022 PARITY: sample one bit at the same point as in DATA.
- Expected bit = XOR of the data bits, inverted for odd parity.
- A mismatch sets the parity error for this frame.
REQ-023 STOP: sample STOP_BITS bits at the same point as in DATA. Any sample of 0 sets the frame error for this frame.
REQ-024 On the cycle of the last stop sample:
- Push {data, parity error, frame error} into the FIFO.
- Go directly to IDLE.
- This allows back-to-back frames with no extra idle time.
REQ-025 A frame with parity or framing errors SHALL still be pushed, with its flags set.
REQ-026 Timing: rxValid SHALL rise on the clock edge after the push cycle when the FIFO was empty (1-cycle write latency).
REQ-027 Handshake: a pop SHALL occur when rxValid && rxReady at a rising edge.
- The next entry, if any, appears on the following cycle.
- rxData and the flags SHALL hold stable while rxValid = 1 and rxReady = 0.
REQ-028 Push when the FIFO is full and no pop occurs in the same cycle:
- The new frame is discarded.
- FIFO contents are unchanged.
- overrun pulses for exactly 1 cycle.
REQ-029 Simultaneous push and pop while full: both SHALL take effect, with no overrun and the FIFO staying full.
REQ-030 Simultaneous push and pop while empty: the pushed word becomes the head on the next cycle and rxValid = 1.
REQ-031 FIFO read and write pointers SHALL wrap modulo DEPTH. The FIFO SHALL NOT issue a pop when empty.
REQ-032 When rxValid = 0, rxData, parityErr and frameErr SHALL hold their last values.

Reset
REQ-033 While rstN = 0:
- State = IDLE, counters = 0, FIFO empty, synchronizer = 1.
- Outputs: rxData = 0, parityErr = 0, frameErr = 0, rxValid = 0, overrun = 0, busy = 0.
REQ-034 Reset during a frame SHALL abort it; no partial word is ever pushed.
REQ-035 After rstN is deasserted, the first valid frame SHALL be received normally. A line that is low at release SHALL be treated as a start edge.

Verification
Setup for all scenarios: CLKS_PER_BIT = 16, DATA_BITS = 8, PARITY = 2, STOP_BITS = 1, DEPTH = 4.
REQ-036 Send 0xA5 with parity bit 0 and stop bit 1 -> rxData = 0xA5, parityErr = 0, frameErr = 0, rxValid = 1 until popped.
REQ-037 Send 0x3C with parity bit 1 -> rxData = 0x3C, parityErr = 1, frameErr = 0.
REQ-038 Send 0x81 with correct parity and stop bit 0 -> rxData = 0x81, frameErr = 1; the next frame 0x42 is received correctly.
REQ-039 Hold rxIn low for 4 cycles, then high -> busy pulses, no push, rxValid stays 0.
REQ-040 Hold rxReady = 0 and send 0x01..0x05 back-to-back -> one overrun pulse on the 5th frame; the pops then return 0x01..0x04 in order.
REQ-041 Pull rstN low in DATA after 3 bits of 0xFF, release it, then send 0x5A -> only 0x5A is received; rxValid = 0 before it.
